key_event_ctrl: RTL

//  Classifies key activity into single-click, double-click, long-press and auto-repeat events.

---
 rtl/key_event_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_event_ctrl.sv
// Turns debounced press/release pulses into click, double-click, long-press and auto-repeat events.
// Every output is registered and appears one cycle after its trigger. There is no backpressure: events are fire-and-forget pulses.
module key_event_ctrl #(
    parameter int CNT_W         = 26,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 12_500_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       key_p_flag,
    input  logic       key_r_flag,
    output logic       click_pulse,
    output logic       dclick_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic [2:0] evt_code,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_T = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES - 1);

    localparam logic [2:0] EVT_CLICK  = 3'd1;
    localparam logic [2:0] EVT_DCLICK = 3'd2;
    localparam logic [2:0] EVT_LONG   = 3'd3;
    localparam logic [2:0] EVT_REPEAT = 3'd4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             click_q, click_d;
    logic             dclick_q, dclick_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic [2:0]       evt_q, evt_d;
    logic             busy_q;

    // Simultaneous press and release cancel out.
    logic p_ev, r_ev;
    assign p_ev = key_p_flag & ~key_r_flag;
    assign r_ev = key_r_flag & ~key_p_flag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        evt_d    = evt_q;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (p_ev) state_d = S_PRESS1;
                end
                // A release always beats the timer's terminal cycle.
                S_PRESS1: begin
                    if (r_ev) begin
                        state_d = S_WAIT2;
                        cnt_d   = '0;
                    end else if (cnt_q == LONG_T) begin
                        state_d = S_LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                        evt_d   = EVT_LONG;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT2: begin
                    if (p_ev) begin
                        state_d = S_PRESS2;
                        cnt_d   = '0;
                    end else if (cnt_q == DCLICK_T) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        click_d = 1'b1;
                        evt_d   = EVT_CLICK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PRESS2: begin
                    cnt_d = '0;
                    if (r_ev) begin
                        state_d  = S_IDLE;
                        dclick_d = 1'b1;
                        evt_d    = EVT_DCLICK;
                    end
                end
                S_LONG: begin
                    if (r_ev) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == REPEAT_T) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                        evt_d    = EVT_REPEAT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            evt_q    <= 3'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            click_q  <= click_d;
            dclick_q <= dclick_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            evt_q    <= evt_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign click_pulse  = click_q;
    assign dclick_pulse = dclick_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;
    assign evt_code     = evt_q;
    assign busy         = busy_q;

endmodule
